// File: rtl/tap_scan_master_if.sv
// Request/response handshake between the BIST sequencer and the JTAG scan master.
interface tap_scan_master_if #(
  parameter int IR_WIDTH = 8,
  parameter int DR_MAX   = 32,
  parameter int LEN_W    = $clog2(DR_MAX + 1)
);
  logic                req_valid;
  logic                req_ready;
  logic [IR_WIDTH-1:0] req_ir;
  logic [DR_MAX-1:0]   req_dr;
  logic [LEN_W-1:0]    req_len;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_MAX-1:0]   rsp_dr;

  modport master (
    output req_valid, req_ir, req_dr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_dr
  );

  modport slave (
    input  req_valid, req_ir, req_dr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_dr
  );
endinterface

// File: rtl/tap_scan_master.sv
// JTAG scan initiator: per request, one IR scan then one DR scan of programmable length,
// returning the TDO bits captured during the DR shift. All outputs are registered.
module tap_scan_master #(
  parameter int IR_WIDTH = 8,
  parameter int DR_MAX   = 32,
  parameter int LEN_W    = $clog2(DR_MAX + 1)
) (
  input  logic TCLK,
  input  logic TRESET,
  tap_scan_master_if.slave bus,
  output logic TMS,
  output logic TDI,
  input  logic TDO
);

  localparam int CNT_MAX = (IR_WIDTH > DR_MAX) ? ((IR_WIDTH > 5) ? IR_WIDTH : 5)
                                               : ((DR_MAX > 5) ? DR_MAX : 5);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

  typedef enum logic [3:0] {
    RST_SEQ  = 4'd0,
    IDLE     = 4'd1,
    IR_HDR   = 4'd2,
    IR_SHIFT = 4'd3,
    IR_TAIL  = 4'd4,
    DR_HDR   = 4'd5,
    DR_SHIFT = 4'd6,
    DR_TAIL  = 4'd7,
    RESP     = 4'd8
  } scanState_e;

  scanState_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [IR_WIDTH-1:0] irSh;
  logic [DR_MAX-1:0]   drSh;
  logic [LEN_W-1:0]    lenReg;
  logic [DR_MAX-1:0]   capReg;
  logic                reqReady;
  logic                rspValid;
  logic                tmsReg;
  logic                tdiReg;
  logic [LEN_W-1:0]    effLen;
  logic [CNT_W-1:0]    capIdx;

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_dr    = capReg;
  assign TMS           = tmsReg;
  assign TDI           = tdiReg;

  // Saturated request length, and the DR bit position of the current shift cycle.
  always_comb begin
    if ((bus.req_len == {LEN_W{1'b0}}) || (bus.req_len > LEN_W'(DR_MAX))) begin
      effLen = LEN_W'(DR_MAX);
    end else begin
      effLen = bus.req_len;
    end
    capIdx = CNT_W'(lenReg) - cnt - CNT_W'(1);
  end

  // Scan sequencer: cnt holds the cycles left in the current phase minus one, and the
  // TMS/TDI registers are loaded with the value of the cycle that follows the edge.
  always_ff @(posedge TCLK) begin
    if (TRESET) begin
      state    <= RST_SEQ;
      cnt      <= CNT_W'(5);
      irSh     <= {IR_WIDTH{1'b0}};
      drSh     <= {DR_MAX{1'b0}};
      lenReg   <= {LEN_W{1'b0}};
      capReg   <= {DR_MAX{1'b0}};
      reqReady <= 1'b0;
      rspValid <= 1'b0;
      tmsReg   <= 1'b1;
      tdiReg   <= 1'b0;
    end else begin
      case (state)
        RST_SEQ: begin
          tdiReg <= 1'b0;
          if (cnt != CNT_W'(0)) begin
            cnt    <= cnt - CNT_W'(1);
            tmsReg <= (cnt > CNT_W'(1));
          end else begin
            state    <= IDLE;
            reqReady <= 1'b1;
            tmsReg   <= 1'b0;
          end
        end
        IDLE: begin
          tdiReg <= 1'b0;
          if (bus.req_valid && reqReady) begin
            irSh     <= bus.req_ir;
            drSh     <= bus.req_dr;
            lenReg   <= effLen;
            capReg   <= {DR_MAX{1'b0}};
            reqReady <= 1'b0;
            state    <= IR_HDR;
            cnt      <= CNT_W'(3);
            tmsReg   <= 1'b1;
          end else begin
            tmsReg <= 1'b0;
          end
        end
        IR_HDR: begin
          if (cnt != CNT_W'(0)) begin
            cnt    <= cnt - CNT_W'(1);
            tmsReg <= (cnt >= CNT_W'(3));
            tdiReg <= 1'b0;
          end else begin
            state  <= IR_SHIFT;
            cnt    <= CNT_W'(IR_WIDTH - 1);
            tmsReg <= (IR_WIDTH == 1) ? 1'b1 : 1'b0;
            tdiReg <= irSh[0];
          end
        end
        IR_SHIFT: begin
          if (cnt != CNT_W'(0)) begin
            cnt    <= cnt - CNT_W'(1);
            tmsReg <= (cnt == CNT_W'(1));
            tdiReg <= irSh[1];
            irSh   <= irSh >> 1;
          end else begin
            state  <= IR_TAIL;
            cnt    <= CNT_W'(1);
            tmsReg <= 1'b1;
            tdiReg <= 1'b0;
          end
        end
        IR_TAIL: begin
          tdiReg <= 1'b0;
          if (cnt != CNT_W'(0)) begin
            cnt    <= CNT_W'(0);
            tmsReg <= 1'b0;
          end else begin
            state  <= DR_HDR;
            cnt    <= CNT_W'(2);
            tmsReg <= 1'b1;
          end
        end
        DR_HDR: begin
          if (cnt != CNT_W'(0)) begin
            cnt    <= cnt - CNT_W'(1);
            tmsReg <= 1'b0;
            tdiReg <= 1'b0;
          end else begin
            state  <= DR_SHIFT;
            cnt    <= CNT_W'(lenReg) - CNT_W'(1);
            tmsReg <= (lenReg == LEN_W'(1));
            tdiReg <= drSh[0];
          end
        end
        DR_SHIFT: begin
          // TDO belongs to the cycle this edge ends.
          capReg[capIdx[IDX_W-1:0]] <= TDO;
          if (cnt != CNT_W'(0)) begin
            cnt    <= cnt - CNT_W'(1);
            tmsReg <= (cnt == CNT_W'(1));
            tdiReg <= drSh[1];
            drSh   <= drSh >> 1;
          end else begin
            state  <= DR_TAIL;
            cnt    <= CNT_W'(1);
            tmsReg <= 1'b1;
            tdiReg <= 1'b0;
          end
        end
        DR_TAIL: begin
          tdiReg <= 1'b0;
          tmsReg <= 1'b0;
          if (cnt != CNT_W'(0)) begin
            cnt <= CNT_W'(0);
          end else begin
            state    <= RESP;
            rspValid <= 1'b1;
          end
        end
        RESP: begin
          tmsReg <= 1'b0;
          tdiReg <= 1'b0;
          if (bus.rsp_ready) begin
            state    <= IDLE;
            rspValid <= 1'b0;
            reqReady <= 1'b1;
          end else begin
            rspValid <= 1'b1;
          end
        end
        default: begin
          state    <= RST_SEQ;
          cnt      <= CNT_W'(5);
          reqReady <= 1'b0;
          rspValid <= 1'b0;
          tmsReg   <= 1'b1;
          tdiReg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_scan_master.sv
// Bench for tap_scan_master: a behavioural 16-state TAP with per-address TDRs sits on the
// serial pins; table vectors, random scans and hand-written reset sequences are checked.
module tb_tap_scan_master;

  localparam int IRW = 8;
  localparam int DRM = 32;
  localparam int LW  = 6;

  logic TCLK = 1'b0;
  logic TRESET;
  logic TMS, TDI, TDO;

  int vectors     = 0;
  int miscompares = 0;

  tap_scan_master_if #(.IR_WIDTH(IRW), .DR_MAX(DRM), .LEN_W(LW)) bus ();

  tap_scan_master #(.IR_WIDTH(IRW), .DR_MAX(DRM), .LEN_W(LW)) dut (
    .TCLK   (TCLK),
    .TRESET (TRESET),
    .bus    (bus),
    .TMS    (TMS),
    .TDI    (TDI),
    .TDO    (TDO)
  );

  always #5 TCLK = ~TCLK;

  // ---------------- behavioural target TAP ----------------
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPIR} tap_e;

  tap_e        tapSt = TLR;
  logic [7:0]  irSr, irPar;
  logic [31:0] drSr, drIn;
  int          drCnt;
  logic [31:0] tdrPar [256];

  function automatic logic [31:0] capOf(input logic [7:0] a);
    if (a == 8'd45) return 32'h000000CF;
    return {a, ~a, a ^ 8'h5A, a + 8'd3};
  endfunction

  function automatic tap_e nextTap(input tap_e s, input logic t);
    logic m;
    m = (t === 1'b1);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PAUSEDR;
      PAUSEDR: return m ? EX2DR : PAUSEDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAUSEIR;
      PAUSEIR: return m ? EX2IR : PAUSEIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  assign TDO = (tapSt == SHDR) ? drSr[0] : 1'b0;

  always @(posedge TCLK) begin
    case (tapSt)
      TLR:   irPar <= 8'hFF;
      CAPIR: irSr  <= 8'h01;
      SHIR:  irSr  <= {TDI, irSr[7:1]};
      UPIR:  irPar <= irSr;
      CAPDR: begin drSr <= capOf(irPar); drIn <= 32'h0; drCnt <= 0; end
      SHDR:  begin
        drSr <= drSr >> 1;
        if (drCnt < 32) drIn[drCnt] <= TDI;
        drCnt <= drCnt + 1;
      end
      UPDR:  tdrPar[irPar] <= drIn;
      default: ;
    endcase
    tapSt <= nextTap(tapSt, TMS);
  end

  // ---------------- reference rules ----------------
  function automatic int effLen(input logic [LW-1:0] l);
    return ((l == 0) || (l > 32)) ? 32 : int'(l);
  endfunction

  function automatic logic [31:0] lenMask(input int l);
    return (l >= 32) ? 32'hFFFFFFFF : ((32'h1 << l) - 32'h1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge after TRESET has been sampled high; releases it and checks replay.
  task automatic checkResetSeq();
    check("rst_tms", {31'b0, TMS}, 32'd1);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_dr", bus.rsp_dr, 32'h0);
    TRESET = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge TCLK);
      check($sformatf("rstseq_tms_e%0d", e), {31'b0, TMS}, (e < 5) ? 32'd1 : 32'd0);
      check($sformatf("rstseq_ready_e%0d", e), {31'b0, bus.req_ready}, (e == 6) ? 32'd1 : 32'd0);
      check($sformatf("rstseq_rspv_e%0d", e), {31'b0, bus.rsp_valid}, 32'd0);
    end
  endtask

  task automatic doScan(input logic [7:0] ir, input logic [31:0] dr, input logic [LW-1:0] len,
                        input int delay, input logic [31:0] expRsp, input int expN,
                        input logic [31:0] expPar);
    logic [3:0] act[$];
    logic [3:0] ex[$];
    int L, waited, bad, n;
    L = effLen(len);
    waited = 0;
    while ((bus.req_ready !== 1'b1) && (waited < 100)) begin
      @(negedge TCLK);
      waited++;
    end
    check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_ir = ir; bus.req_dr = dr; bus.req_len = len;
    @(posedge TCLK);
    #1;
    bus.req_valid = 1'b0;
    bus.req_ir = 8'($urandom); bus.req_dr = $urandom; bus.req_len = LW'($urandom);
    for (int i = 0; i < expN; i++) begin
      @(negedge TCLK);
      act.push_back({TMS, TDI, bus.req_ready, bus.rsp_valid});
    end
    // Expected pin stream: {TMS, TDI, req_ready, rsp_valid} per cycle.
    ex.push_back(4'b1000); ex.push_back(4'b1000); ex.push_back(4'b0000); ex.push_back(4'b0000);
    for (int k = 0; k < 8; k++) ex.push_back({(k == 7), ir[k], 2'b00});
    ex.push_back(4'b1000); ex.push_back(4'b0000);
    ex.push_back(4'b1000); ex.push_back(4'b0000); ex.push_back(4'b0000);
    for (int k = 0; k < L; k++) ex.push_back({(k == L - 1), dr[k], 2'b00});
    ex.push_back(4'b1000); ex.push_back(4'b0000);
    bad = -1;
    n = (act.size() > ex.size()) ? act.size() : ex.size();
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && ((i >= act.size()) || (i >= ex.size()) || (act[i] !== ex[i]))) bad = i;
    end
    check("pin_stream_first_bad_cycle", 32'(bad), 32'hFFFFFFFF);
    @(negedge TCLK);
    check("rsp_valid_rise", {31'b0, bus.rsp_valid}, 32'd1);
    check("rsp_dr", bus.rsp_dr, expRsp);
    for (int c = 0; c < delay; c++) begin
      check("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("hold_rsp_dr", bus.rsp_dr, expRsp);
      check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      if (c == delay / 2) bus.req_valid = 1'b1;
      @(negedge TCLK);
      bus.req_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge TCLK);
    bus.rsp_ready = 1'b0;
    check("consume_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("consume_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("tap_ir", {24'h0, irPar}, {24'h0, ir});
    check("tdr_parallel", tdrPar[ir], expPar);
    check("tap_in_idle", 32'(tapSt), 32'(RTI));
    @(negedge TCLK);
    check("gap_tms", {31'b0, TMS}, 32'd0);
    check("gap_req_ready", {31'b0, bus.req_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]    ir;
    logic [31:0]   dr;
    logic [LW-1:0] len;
    int            delay;
    logic [31:0]   expRsp;
    int            expN;
    logic [31:0]   expPar;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]    rir;
    logic [31:0]   rdr;
    logic [LW-1:0] rlen;
    int            rl;

    tbl[0] = '{8'h2D, 32'h0001A5A5, 6'd17, 0,  32'h000000CF, 36, 32'h0001A5A5};
    tbl[1] = '{8'h2D, 32'h0001A5A5, 6'd17, 10, 32'h000000CF, 36, 32'h0001A5A5};
    tbl[2] = '{8'h2D, 32'hFFFFFFFF, 6'd1,  0,  32'h00000001, 20, 32'h00000001};
    tbl[3] = '{8'h2D, 32'hDEADBEEF, 6'd0,  2,  32'h000000CF, 51, 32'hDEADBEEF};
    tbl[4] = '{8'h2D, 32'h12345678, 6'd40, 0,  32'h000000CF, 51, 32'h12345678};
    tbl[5] = '{8'h10, 32'h0000ABCD, 6'd8,  1,  32'h00000013, 27, 32'h000000CD};
    tbl[6] = '{8'hA3, 32'h0F0F0F0F, 6'd32, 0,  32'hA35CF9A6, 51, 32'h0F0F0F0F};

    TRESET = 1'b1;
    bus.req_valid = 1'b0; bus.req_ir = 8'h0; bus.req_dr = 32'h0; bus.req_len = 6'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge TCLK);
    @(negedge TCLK);
    checkResetSeq();

    foreach (tbl[i])
      doScan(tbl[i].ir, tbl[i].dr, tbl[i].len, tbl[i].delay,
             tbl[i].expRsp, tbl[i].expN, tbl[i].expPar);

    for (int r = 0; r < 24; r++) begin
      rir  = 8'($urandom_range(0, 255));
      rdr  = $urandom;
      rlen = LW'($urandom_range(0, 40));
      rl   = effLen(rlen);
      doScan(rir, rdr, rlen, $urandom_range(0, 3), capOf(rir) & lenMask(rl), 19 + rl,
             rdr & lenMask(rl));
    end

    // Reset during DR shift bit 5 (cycle 23 after the accepting edge).
    bus.req_valid = 1'b1; bus.req_ir = 8'h2D; bus.req_dr = 32'h0001A5A5; bus.req_len = 6'd17;
    @(posedge TCLK);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 23; i++) @(negedge TCLK);
    TRESET = 1'b1;
    @(negedge TCLK);
    checkResetSeq();
    doScan(8'h2D, 32'h0001A5A5, 6'd17, 0, 32'h000000CF, 36, 32'h0001A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
